// File: rtl/la_pattern_gen.sv
// Test-pattern generator for logic-analyser bring-up: binary, Gray, walking-one or Galois LFSR
// patterns stepped at a prescaled rate, in continuous or fixed-length bursts.
module la_pattern_gen #(
    parameter int                WIDTH      = 8,
    parameter int                PRESCALE_W = 16,
    parameter int                BURST_W    = 16,
    parameter logic [WIDTH-1:0]  LFSR_POLY  = 8'hB8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BURST_W-1:0]    burst_len,
    output logic [WIDTH-1:0]      port,
    output logic                  strobe,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {MODE_BIN, MODE_GRAY, MODE_WALK, MODE_LFSR} mode_t;
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                r_state,  w_state_nxt;
    mode_t                 r_mode,   w_mode_nxt;
    logic [PRESCALE_W-1:0] r_p,      w_p_nxt;
    logic [PRESCALE_W-1:0] r_pcnt,   w_pcnt_nxt;
    logic [BURST_W-1:0]    r_b,      w_b_nxt;
    logic [BURST_W-1:0]    r_step,   w_step_nxt;
    logic [WIDTH-1:0]      r_bin,    w_bin_nxt;
    logic [WIDTH-1:0]      r_port,   w_port_nxt;
    logic                  r_strobe, w_strobe_nxt;
    logic                  r_done,   w_done_nxt;

    logic [WIDTH-1:0]      w_bin_inc;
    logic [BURST_W-1:0]    w_step_inc;
    logic [WIDTH-1:0]      w_adv;
    logic [WIDTH-1:0]      w_seed;

    assign w_bin_inc  = r_bin + WIDTH'(1);
    // Step count only decides burst end, so saturating it keeps continuous runs harmless.
    assign w_step_inc = (r_step == '1) ? r_step : r_step + BURST_W'(1);

    always_comb begin
        unique case (r_mode)
            MODE_BIN:  w_adv = w_bin_inc;
            MODE_GRAY: w_adv = w_bin_inc ^ (w_bin_inc >> 1);
            MODE_WALK: w_adv = {r_port[WIDTH-2:0], r_port[WIDTH-1]};
            default:   w_adv = (r_port >> 1) ^ (r_port[0] ? LFSR_POLY : '0);
        endcase
    end

    always_comb begin
        unique case (mode_t'(mode))
            MODE_WALK: w_seed = WIDTH'(1);
            MODE_LFSR: w_seed = '1;
            default:   w_seed = '0;
        endcase
    end

    // NOTE: every next-state signal gets a default before the case, so no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_p_nxt      = r_p;
        w_b_nxt      = r_b;
        w_pcnt_nxt   = r_pcnt;
        w_step_nxt   = r_step;
        w_bin_nxt    = r_bin;
        w_port_nxt   = r_port;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_mode_nxt  = mode_t'(mode);
                    w_p_nxt     = prescale;
                    w_b_nxt     = burst_len;
                    w_pcnt_nxt  = '0;
                    w_step_nxt  = '0;
                    w_bin_nxt   = '0;
                    w_port_nxt  = w_seed;
                end
            end
            default: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_pcnt == r_p) begin
                    w_pcnt_nxt   = '0;
                    w_step_nxt   = w_step_inc;
                    w_bin_nxt    = w_bin_inc;
                    w_port_nxt   = w_adv;
                    w_strobe_nxt = 1'b1;
                    if ((r_b != '0) && (w_step_inc == r_b)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_pcnt_nxt = r_pcnt + PRESCALE_W'(1);
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_mode   <= MODE_BIN;
            r_p      <= '0;
            r_b      <= '0;
            r_pcnt   <= '0;
            r_step   <= '0;
            r_bin    <= '0;
            r_port   <= '0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode   <= w_mode_nxt;
            r_p      <= w_p_nxt;
            r_b      <= w_b_nxt;
            r_pcnt   <= w_pcnt_nxt;
            r_step   <= w_step_nxt;
            r_bin    <= w_bin_nxt;
            r_port   <= w_port_nxt;
            r_strobe <= w_strobe_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign port   = r_port;
    assign strobe = r_strobe;
    assign done   = r_done;
    assign busy   = (r_state == S_RUN);

endmodule
